// File: rtl/axi_request_arbiter_if.sv
// axi_request_arbiter_if: bundles the two requester handshakes, the single
// downstream port toward axi_controller, and the arbiter status outputs.
//   r0_* / r1_*  : fetch (0) and load/store (1) request handshakes
//   m_*          : muxed handshake toward axi_controller
//   grant, err   : one-hot current owner, protocol-violation pulse
// Modport slave is the arbiter's view; master is the surrounding logic's view.
interface axi_request_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              r0_read, r0_write, r0_done, r0_ready;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_store, r0_load;
  logic              r1_read, r1_write, r1_done, r1_ready;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_store, r1_load;
  logic              m_read, m_write, m_done, m_ready;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_store, m_load;
  logic [1:0]        grant;
  logic              err;

  modport slave (
    input  r0_read, r0_write, r0_addr, r0_store, r0_done,
    input  r1_read, r1_write, r1_addr, r1_store, r1_done,
    input  m_ready, m_load,
    output r0_ready, r0_load, r1_ready, r1_load,
    output m_read, m_write, m_addr, m_store, m_done,
    output grant, err
  );

  modport master (
    output r0_read, r0_write, r0_addr, r0_store, r0_done,
    output r1_read, r1_write, r1_addr, r1_store, r1_done,
    output m_ready, m_load,
    input  r0_ready, r0_load, r1_ready, r1_load,
    input  m_read, m_write, m_addr, m_store, m_done,
    input  grant, err
  );
endinterface

// File: rtl/axi_request_arbiter.sv
// axi_request_arbiter: round-robin arbiter between instruction fetch (r0) and
// data load/store (r1) in front of a single axi_controller port.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : axi_request_arbiter_if.slave (requesters, m_* port, grant, err)
// A grant is held until m_ready && done of the owner; the downstream
// handshake is a pure combinational mux of the owner's signals.
module axi_request_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_request_arbiter_if.slave bus
);
  // State encoding doubles as the one-hot grant output.
  typedef enum logic [1:0] {IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10} state_t;

  state_t state, state_nxt;
  logic   v0, v1, ill0, ill1, ill0_q, ill1_q;
  logic   last, drop_seen, err_q, done_hit, dropped;

  assign v0   = bus.r0_read ^ bus.r0_write;
  assign v1   = bus.r1_read ^ bus.r1_write;
  assign ill0 = bus.r0_read & bus.r0_write;
  assign ill1 = bus.r1_read & bus.r1_write;

  assign done_hit = bus.m_ready & (((state == GNT0) & bus.r0_done) |
                                   ((state == GNT1) & bus.r1_done));
  assign dropped  = ((state == GNT0) & ~bus.r0_read & ~bus.r0_write) |
                    ((state == GNT1) & ~bus.r1_read & ~bus.r1_write);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: on completion hand off directly if the other side waits,
  // otherwise fall back to IDLE (never re-grant the same requester directly).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (v0 && v1)  state_nxt = last ? GNT0 : GNT1;
        else if (v0)   state_nxt = GNT0;
        else if (v1)   state_nxt = GNT1;
      end
      GNT0: if (bus.m_ready && bus.r0_done) state_nxt = v1 ? GNT1 : IDLE;
      GNT1: if (bus.m_ready && bus.r1_done) state_nxt = v0 ? GNT0 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Round-robin pointer and error bookkeeping. An illegal request pulses err
  // only on its first cycle; a dropped grant pulses once per grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last      <= 1'b1;
      drop_seen <= 1'b0;
      ill0_q    <= 1'b0;
      ill1_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ill0_q <= ill0;
      ill1_q <= ill1;
      err_q  <= (ill0 & ~ill0_q) | (ill1 & ~ill1_q) | (dropped & ~drop_seen);
      if (done_hit) begin
        last      <= (state == GNT1);
        drop_seen <= 1'b0;
      end else if (dropped) begin
        drop_seen <= 1'b1;
      end
    end
  end

  // Output mux: everything is zero unless a grant is held.
  always_comb begin
    bus.m_read   = 1'b0;
    bus.m_write  = 1'b0;
    bus.m_addr   = '0;
    bus.m_store  = '0;
    bus.m_done   = 1'b0;
    bus.r0_ready = 1'b0;
    bus.r0_load  = '0;
    bus.r1_ready = 1'b0;
    bus.r1_load  = '0;
    case (state)
      GNT0: begin
        bus.m_read   = bus.r0_read;
        bus.m_write  = bus.r0_write;
        bus.m_addr   = bus.r0_addr;
        bus.m_store  = bus.r0_store;
        bus.m_done   = bus.r0_done;
        bus.r0_ready = bus.m_ready;
        bus.r0_load  = bus.m_load;
      end
      GNT1: begin
        bus.m_read   = bus.r1_read;
        bus.m_write  = bus.r1_write;
        bus.m_addr   = bus.r1_addr;
        bus.m_store  = bus.r1_store;
        bus.m_done   = bus.r1_done;
        bus.r1_ready = bus.m_ready;
        bus.r1_load  = bus.m_load;
      end
      default: ;
    endcase
  end

  assign bus.grant = state;
  assign bus.err   = err_q;
endmodule
